// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word reads to a one-cycle-latency memory, buffers
// returned words in a small prefetch queue and hands them to decode.
module fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [15:0]       imem_rdata,
  output logic              instr_valid,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              decode_stall
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_O = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic              inflight;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [15:0]       q_instr [DEPTH];
  logic [ADDR_W-1:0] q_pc    [DEPTH];

  logic [CNT_W:0] occupancy;
  logic           push;
  logic           pop;

  // An in-flight request already owns a slot, so issuing only on spare credit
  // means a returning word can never find the queue full.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign imem_req  = rst_n && fetch_en && !redirect_valid && (occupancy < DEPTH_O);
  assign imem_addr = pc;

  assign push = rst_n && imem_rvalid && inflight && !redirect_valid;
  assign pop  = rst_n && instr_valid && !decode_stall && !redirect_valid;

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? q_instr[rd_ptr] : 16'h0000;
  assign instr_pc    = instr_valid ? q_pc[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        pc     <= pc + ADDR_W'(1);
        req_pc <= pc;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]    <= req_pc;
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= DEPTH_C);

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage feeding the decode stage. Generates word addresses for a fixed-latency instruction memory, buffers returned instructions in a small prefetch queue, and presents them to decode through a valid/stall handshake. Supports branch redirect with queue flush and honours decode back-pressure without losing or duplicating instructions.

## Interface
- ADDR_W, 8, instruction word-address width
- DEPTH, 4, prefetch queue entries (power of two, ≥2)
- RESET_PC, 0, first fetch address after reset

- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- fetch_en  input  1  permits new memory requests; queue drains regardless
- redirect_valid  input  1  branch/jump redirect pulse
- redirect_pc  input  ADDR_W  redirect target word address
- imem_req  output  1  memory read request (combinational)
- imem_addr  output  ADDR_W  request address (= pc register)
- imem_rvalid  input  1  read data valid, exactly 1 cycle after imem_req
- imem_rdata  input  16  instruction word
- instr_valid  output  1  queue head valid toward decode
- instr  output  16  queue head instruction; 16'h0000 when instr_valid=0
- instr_pc  output  ADDR_W  address of queue head; 0 when instr_valid=0
- decode_stall  input  1  decode cannot accept this cycle

## Operation
- State: pc (ADDR_W), queue of DEPTH entries {instr, pc}, rd/wr pointers, count (0..DEPTH), inflight (1 bit), req_pc (ADDR_W, address of in-flight request).
- Reset: pc=RESET_PC, count=0, pointers=0, inflight=0; outputs imem_req=0 (while rst_n=0), instr_valid=0, instr=0, instr_pc=0.
- Request: imem_req = rst_n && fetch_en && !redirect_valid && (count + inflight < DEPTH). On issue: pc <= pc+1 (wraps modulo 2^ADDR_W), inflight <= 1, req_pc <= pc. No issue: inflight <= 0.
- Response: on imem_rvalid && inflight && !redirect_valid, write {imem_rdata, req_pc} at wr pointer, count+1. imem_rvalid with inflight=0 ignored. Credit rule guarantees no write when full; count never exceeds DEPTH.
- Consume: pop when instr_valid && !decode_stall && !redirect_valid; rd pointer+1, count-1. While decode_stall=1, instr/instr_pc held stable.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Redirect: queue flushed (count=0, pointers reset), response arriving same cycle dropped, no request that cycle, pc <= redirect_pc, inflight <= 0. Redirect has priority over push, pop and issue.
- fetch_en=0: no new requests; in-flight response still accepted; queue drains normally.
- rst_n low mid-operation: all state returns to reset values next edge; pending response discarded.

## Timing
- Request in cycle N → imem_rvalid in N+1 → instr_valid in N+2 (no bypass).
- Steady state, no stall: one request and one instruction per cycle.
- Redirect in cycle R: instr_valid=0 in R+1; request to redirect_pc in R+1; that instruction valid at R+3.
- After reset release (fetch_en=1) in cycle 0: request RESET_PC in cycle 0, instr_valid first high in cycle 2.
- Stall: with decode_stall held, queue fills to DEPTH then imem_req drops; on release, throughput resumes at one/cycle with no bubble while queue non-empty.
- instr_valid, instr, instr_pc are registered (driven from queue state only).

## Test plan
- Straight-line: reset, fetch_en=1, memory returns word 16'h1000+addr → decode sees instr_pc 0,1,2,... one per cycle from cycle 2, instr matching addresses.
- Back-pressure: stall decode 10 cycles from cycle 5 → queue reaches 4, imem_req low, instr stable; release → sequence continues with no drop/duplicate.
- Redirect: redirect_valid with redirect_pc=8'h40 while queue holds 3 entries and a response in flight → instr_valid low next cycle, next valid instr_pc=8'h40 three cycles later, stale instructions never presented.
- Wrap: redirect_pc=8'hFE → instr_pc sequence FE, FF, 00, 01.
- fetch_en drop and mid-run reset: fetch_en=0 → in-flight word still delivered, no further requests; rst_n=0 mid-stream → next cycle instr_valid=0, instr=0, fetch restarts at RESET_PC.
- Redirect coincident with pop and response under stall → exactly target-address instructions follow; count never exceeds DEPTH (assert).
